// File: rtl/bp_fe_queue_fifo_if.sv
// FE queue handshake bundle: the FE enqueue channel and the BE read channel.
// The FIFO sits on the slave side. The producer/consumer environment uses the master side.
interface bp_fe_queue_fifo_if #(
    parameter int entry_width_p = 128
);
    // FE -> queue enqueue channel
    logic [entry_width_p-1:0] fe_queue_i;
    logic                     fe_queue_v_i;
    logic                     fe_queue_ready_o;

    // queue -> BE read channel
    logic [entry_width_p-1:0] fe_queue_o;
    logic                     fe_queue_v_o;
    logic                     fe_queue_yumi_i;

    modport slave (
        input  fe_queue_i,
        input  fe_queue_v_i,
        input  fe_queue_yumi_i,
        output fe_queue_ready_o,
        output fe_queue_o,
        output fe_queue_v_o
    );

    modport master (
        output fe_queue_i,
        output fe_queue_v_i,
        output fe_queue_yumi_i,
        input  fe_queue_ready_o,
        input  fe_queue_o,
        input  fe_queue_v_o
    );
endinterface

// File: rtl/bp_fe_queue_fifo.sv
// FE -> BE packet queue with speculative read and commit-based free.
// Three wrap-bit pointers are used: cptr (oldest uncommitted), rptr (next to present)
// and wptr (next free slot). All status is derived from pointer differences.
// Roll rewinds rptr to the post-commit cptr. Clear collapses rptr/wptr onto it.
module bp_fe_queue_fifo #(
    parameter  int entry_width_p = 128,
    parameter  int els_p         = 8,
    localparam int ptr_width_lp  = $clog2(els_p) + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_fe_queue_fifo_if.slave       q_if,
    input  logic                    commit_v_i,
    input  logic                    roll_v_i,
    input  logic                    clr_v_i,
    output logic [ptr_width_lp-1:0] count_o
);

    localparam int idx_width_lp = ptr_width_lp - 1;

    // The wrap-bit scheme only distinguishes full from empty for power-of-two depths.
    if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
        $error("bp_fe_queue_fifo: els_p must be a power of two >= 2");
    end

    logic [ptr_width_lp-1:0] cptr_q, cptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] wptr_q, wptr_d;

    logic [els_p-1:0][entry_width_p-1:0] mem_q, mem_d;

    logic [ptr_width_lp-1:0] occ;
    logic                    full;
    logic                    unread;
    logic                    enq;
    logic                    yumi;
    logic                    commit;
    logic [idx_width_lp-1:0] widx;
    logic [idx_width_lp-1:0] ridx;

    // Status is decoded from registered pointers only, so no input reaches an output.
    always_comb begin
        occ    = wptr_q - cptr_q;
        full   = (occ == ptr_width_lp'(els_p));
        unread = (rptr_q != wptr_q);
        widx   = wptr_q[idx_width_lp-1:0];
        ridx   = rptr_q[idx_width_lp-1:0];
    end

    // Qualified handshakes. A clear kills a same-cycle enqueue.
    always_comb begin
        enq    = q_if.fe_queue_v_i & ~full & ~clr_v_i;
        yumi   = q_if.fe_queue_yumi_i & unread;
        commit = commit_v_i & (cptr_q != rptr_q);
    end

    // Pointer next-state: commit first, then clear > roll > yumi on rptr.
    always_comb begin
        cptr_d = cptr_q + {{(ptr_width_lp-1){1'b0}}, commit};
        rptr_d = rptr_q;
        wptr_d = wptr_q + {{(ptr_width_lp-1){1'b0}}, enq};
        if (clr_v_i) begin
            rptr_d = cptr_d;
            wptr_d = cptr_d;
        end else if (roll_v_i) begin
            rptr_d = cptr_d;
        end else if (yumi) begin
            rptr_d = rptr_q + ptr_width_lp'(1);
        end
    end

    // Storage next-state: only the slot at wptr is written.
    always_comb begin
        mem_d = mem_q;
        if (enq) begin
            mem_d[widx] = q_if.fe_queue_i;
        end
    end

    // Pointer and storage registers. Reset clears contents immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cptr_q <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            mem_q  <= '0;
        end else begin
            cptr_q <= cptr_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            mem_q  <= mem_d;
        end
    end

    // Outputs are muxed straight from registers. There is no enqueue bypass.
    always_comb begin
        q_if.fe_queue_ready_o = ~full;
        q_if.fe_queue_v_o     = unread;
        q_if.fe_queue_o       = mem_q[ridx];
        count_o               = occ;
    end

    // A commit with nothing read-but-uncommitted is a BE protocol error. It is otherwise ignored.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && commit_v_i) begin
            assert (cptr_q != rptr_q)
                else $error("bp_fe_queue_fifo: commit with no read-uncommitted entry");
        end
    end

endmodule

// File: tb/tb_bp_fe_queue_fifo.sv
// Self-checking bench for bp_fe_queue_fifo (els_p=4).
// The reference model is a queue of uncommitted packets plus a count of how many have been read.
// The driver advances the model each cycle. At each yumi it pushes the expected packet into a scoreboard.
// The monitor compares status every negedge and pops the scoreboard on each yumi.
module tb_bp_fe_queue_fifo;
    localparam int W   = 128;
    localparam int ELS = 4;
    localparam int PW  = $clog2(ELS) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          commit_v = 1'b0;
    logic          roll_v = 1'b0;
    logic          clr_v = 1'b0;
    logic [PW-1:0] count;

    bp_fe_queue_fifo_if #(.entry_width_p(W)) q_if ();

    bp_fe_queue_fifo #(.entry_width_p(W), .els_p(ELS)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .q_if       (q_if),
        .commit_v_i (commit_v),
        .roll_v_i   (roll_v),
        .clr_v_i    (clr_v),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    // reference model
    logic [W-1:0] mq[$];
    int           nread;
    // scoreboard of packets expected at each yumi
    logic [W-1:0] exp_q[$];
    // expected registered status for the current cycle
    int           exp_count;
    bit           exp_v;
    bit           exp_ready;
    logic [W-1:0] exp_data;
    bit           chk_en;
    int           n_pass;
    int           n_total;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // One clock of stimulus, called at posedge+1. Illegal yumi/commit are masked.
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit y, input bit c,
                       input bit r, input bit cl);
        bit mv;
        bit mr;
        mv = (nread < mq.size());
        mr = (mq.size() < ELS);
        y  = y && mv;
        c  = c && (nread > 0);
        exp_count = mq.size();
        exp_v     = mv;
        exp_ready = mr;
        exp_data  = mv ? mq[nread] : '0;
        if (y) exp_q.push_back(mq[nread]);
        q_if.fe_queue_v_i    = v;
        q_if.fe_queue_i      = d;
        q_if.fe_queue_yumi_i = y;
        commit_v = c;
        roll_v   = r;
        clr_v    = cl;
        if (c) begin
            void'(mq.pop_front());
            nread--;
        end
        if (cl) begin
            mq.delete();
            nread = 0;
        end else begin
            if (r) nread = 0;
            else if (y) nread++;
            if (v && mr) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Read and commit everything outstanding.
    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 64) begin
            cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        n_total++;
        if (mq.size() == 0) n_pass++;
        else $display("FAIL drain_bound: %0d entries left, expected 0", mq.size());
        idle();
    endtask

    // Reset asserted between edges. The outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        q_if.fe_queue_v_i    = 1'b0;
        q_if.fe_queue_yumi_i = 1'b0;
        commit_v  = 1'b0;
        roll_v    = 1'b0;
        clr_v     = 1'b0;
        exp_count = 0;
        exp_v     = 1'b0;
        exp_ready = 1'b1;
        mq.delete();
        nread = 0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_v", q_if.fe_queue_v_o, 0);
        chk("async_rst_ready", q_if.fe_queue_ready_o, 1);
        chk("async_rst_data", q_if.fe_queue_o, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // monitor: status every cycle, scoreboard pop on every yumi
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count_o", count, exp_count);
            chk("v_o", q_if.fe_queue_v_o, exp_v);
            chk("ready_o", q_if.fe_queue_ready_o, exp_ready);
            if (exp_v) chk("fe_queue_o", q_if.fe_queue_o, exp_data);
            if (q_if.fe_queue_yumi_i) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL yumi_scoreboard: yumi with no expected packet (t=%0t)", $time);
                end else begin
                    chk("yumi_data", q_if.fe_queue_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        q_if.fe_queue_i      = '0;
        q_if.fe_queue_v_i    = 1'b0;
        q_if.fe_queue_yumi_i = 1'b0;
        nread   = 0;
        chk_en  = 1'b0;
        n_pass  = 0;
        n_total = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", q_if.fe_queue_ready_o, 1);
        chk("rst_v", q_if.fe_queue_v_o, 0);
        chk("rst_count", count, 0);
        chk("rst_data", q_if.fe_queue_o, 0);
        exp_count = 0;
        exp_v     = 1'b0;
        exp_ready = 1'b1;
        chk_en    = 1'b1;

        // fill / drain: A..D in order, full after D
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(32'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // roll: A,B,C; yumi A,B; commit A; roll -> B then C
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'hB0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // clear together with commit and enqueue of D. D must not appear.
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, W'(32'hCD), 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        cyc(1'b1, W'(32'hCE), 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // wrap-around: 10 rounds of 3 entries, values 0..29
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) cyc(1'b1, W'(r * 3 + k), 1'b0, 1'b0, 1'b0, 1'b0);
            drain();
        end

        // full boundary: E held while full, accepted the cycle after a commit
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(32'hD0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'hEE), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, W'(32'hEE), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, W'(32'hEE), 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, W'(32'hEE), 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        drain();

        // async reset mid-stream: 3 queued, 1 read
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(32'hF0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset();
        idle();
        cyc(1'b1, W'(32'hF9), 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // randomized mix of all operations
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
        end
        drain();

        chk("scoreboard_empty", W'(exp_q.size()), 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
